// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave with a local register-array memory.
// Accepts pipelined address/data phases, inserts WAIT_STATES wait cycles per
// OKAY beat, and returns the two-cycle ERROR response for illegal transfers.
// Optional macro AHB_SLV_RETRY_EN adds the slave_busy input and the two-cycle
// RETRY response.
module ahb_sram_slave #(
  parameter int          MEM_DEPTH   = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
`ifdef AHB_SLV_RETRY_EN
  ,
  input  logic        slave_busy
`endif
);

  localparam int          AW    = $clog2(MEM_DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
`ifdef AHB_SLV_RETRY_EN
    ,
    ST_RTY1,
    ST_RTY2
`endif
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      wait_cnt;
  logic [31:0]     cap_addr;
  logic            cap_write;
  logic [2:0]      cap_size;
  logic [31:0]     mem [MEM_DEPTH];

  logic            accept;
  logic            capture;
  logic            misaligned;
  logic            in_range;
  logic            legal;
  logic [3:0]      byte_en;
  logic [AW-1:0]   word_idx;
  logic            unused_bits;

  // A new address phase is only taken while no data phase is stalling the bus.
  always_comb begin
    accept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
`ifdef AHB_SLV_RETRY_EN
    if (state == ST_RTY2) accept = 1'b1;
`endif
    capture    = accept && HSEL && HREADY && HTRANS[1];
    misaligned = ((HSIZE == 3'b001) && HADDR[0]) ||
                 ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
    in_range   = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < LIMIT);
    legal      = (HSIZE <= 3'b010) && !misaligned && in_range;
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state selection; accepting states chain straight into the next beat.
  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT: if (wait_cnt == WS) next_state = ST_DONE;
      ST_ERR1: next_state = ST_ERR2;
`ifdef AHB_SLV_RETRY_EN
      ST_RTY1: next_state = ST_RTY2;
`endif
      default: begin
        if (!capture)                next_state = ST_IDLE;
        else if (!legal)             next_state = ST_ERR1;
`ifdef AHB_SLV_RETRY_EN
        else if (slave_busy)         next_state = ST_RTY1;
`endif
        else if (WS != 4'd0)         next_state = ST_WAIT;
        else                         next_state = ST_DONE;
      end
    endcase
  end

  // Address-phase capture and wait counter (counts 1..WAIT_STATES in WAIT).
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cap_addr  <= 32'd0;
      cap_write <= 1'b0;
      cap_size  <= 3'd0;
      wait_cnt  <= 4'd0;
    end else begin
      if (capture) begin
        cap_addr  <= HADDR;
        cap_write <= HWRITE;
        cap_size  <= HSIZE;
      end
      if (next_state == ST_WAIT)
        wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd1;
      else
        wait_cnt <= 4'd0;
    end
  end

  // Little-endian byte lanes touched by the captured size and low address bits.
  always_comb begin
    word_idx = cap_addr[AW+1:2];
    case (cap_size[1:0])
      2'b00:   byte_en = 4'b0001 << cap_addr[1:0];
      2'b01:   byte_en = cap_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Bus response outputs decoded from the state; read data only in DONE.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = 32'd0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DONE: if (!cap_write) HRDATA = mem[word_idx];
      ST_ERR1: begin HREADYOUT = 1'b0; HRESP = 2'b01; end
      ST_ERR2: HRESP = 2'b01;
`ifdef AHB_SLV_RETRY_EN
      ST_RTY1: begin HREADYOUT = 1'b0; HRESP = 2'b10; end
      ST_RTY2: HRESP = 2'b10;
`endif
      default: ;
    endcase
  end

  // Memory write commits at the end of a write's DONE cycle; never cleared.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state == ST_DONE) && cap_write) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  assign unused_bits = ^{HBURST, HTRANS[0], cap_addr[31:AW+2], cap_size[2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave.
// Three slaves share one AHB bus: s0 (base 0x000, 1 wait), s1 (base 0x100,
// 0 waits), s2 (base 0x200, 3 waits). A pipelined master task drives beats and
// pushes expected responses; a monitor pops them when each data phase ends.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        ext_hold;
  logic        hready;
  logic [2:0]  hreadyout_v;
  logic [1:0]  hresp_v  [3];
  logic [31:0] hrdata_v [3];
  logic [1:0]  cur_tgt;
  logic [1:0]  dp_tgt;
  logic        dp_active;
  logic [31:0] pend_wdata;
`ifdef AHB_SLV_RETRY_EN
  logic        busy;
`endif

  typedef struct {
    string       tag;
    logic [1:0]  resp;
    logic        chk;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Free-running bus clock.
  always #5 HCLK = ~HCLK;

  assign hready = ext_hold ? 1'b0 : hreadyout_v[dp_tgt];

  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_s0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout_v[0]), .HRESP(hresp_v[0]), .HRDATA(hrdata_v[0])
`ifdef AHB_SLV_RETRY_EN
    , .slave_busy(busy)
`endif
  );

  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(0)) u_s1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout_v[1]), .HRESP(hresp_v[1]), .HRDATA(hrdata_v[1])
`ifdef AHB_SLV_RETRY_EN
    , .slave_busy(busy)
`endif
  );

  ahb_sram_slave #(.MEM_DEPTH(64), .BASE_ADDR(32'h0000_0200), .WAIT_STATES(3)) u_s2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout_v[2]), .HRESP(hresp_v[2]), .HRDATA(hrdata_v[2])
`ifdef AHB_SLV_RETRY_EN
    , .slave_busy(busy)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  // Bus-level data-phase tracking, as the interconnect mux would do it.
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_active <= 1'b0;
      dp_tgt    <= 2'd0;
    end else if (hready) begin
      dp_active <= htrans[1] && (hsel != 3'b000);
      dp_tgt    <= cur_tgt;
    end
  end

  // Monitor: counts stall cycles and scores each completed data phase.
  int         waits_seen = 0;
  logic [1:0] first_resp = 2'b00;
  always begin
    exp_t e;
    @(negedge HCLK);
    #1;
    if (!dp_active) begin
      waits_seen = 0;
    end else if (!hready) begin
      if (waits_seen == 0) first_resp = hresp_v[dp_tgt];
      waits_seen++;
    end else begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.tag, "_resp"}, 32'(hresp_v[dp_tgt]), 32'(e.resp));
        checkOutput({e.tag, "_waits"}, 32'(waits_seen), 32'(e.waits));
        if (waits_seen > 0)
          checkOutput({e.tag, "_lowresp"}, 32'(first_resp), 32'(e.resp));
        if (e.chk)
          checkOutput({e.tag, "_data"}, hrdata_v[dp_tgt], e.data);
      end
      waits_seen = 0;
    end
  end

  // Drives one pipelined address phase (plus the previous beat's write data)
  // and returns just before the edge that accepts it.
  task automatic applyStimulus(input int tgt, input logic [31:0] addr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] wd, input logic [1:0] tr,
                               input bit push, input string tag, input logic [1:0] eresp,
                               input logic [31:0] edata, input int ewaits);
    int   budget;
    exp_t e;
    @(negedge HCLK);
    hwdata  = pend_wdata;
    cur_tgt = 2'(tgt);
    hsel    = (tr == 2'b00) ? 3'b000 : 3'(1 << tgt);
    haddr   = addr;
    hwrite  = wr;
    hsize   = sz;
    htrans  = tr;
    budget  = 0;
    while (!hready && budget < 64) begin
      @(negedge HCLK);
      budget++;
    end
    if (!hready) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    if (push) begin
      e.tag   = tag;
      e.resp  = eresp;
      e.chk   = !wr;
      e.data  = edata;
      e.waits = ewaits;
      exp_q.push_back(e);
    end
    pend_wdata = wd;
  endtask

  task automatic writeBeat(input int tgt, input logic [31:0] addr, input logic [2:0] sz,
                           input logic [31:0] wd, input logic [1:0] tr, input string tag,
                           input logic [1:0] eresp, input int ewaits);
    applyStimulus(tgt, addr, 1'b1, sz, wd, tr, 1'b1, tag, eresp, 32'd0, ewaits);
  endtask

  task automatic readBeat(input int tgt, input logic [31:0] addr, input logic [2:0] sz,
                          input logic [1:0] tr, input string tag, input logic [1:0] eresp,
                          input logic [31:0] edata, input int ewaits);
    applyStimulus(tgt, addr, 1'b0, sz, 32'd0, tr, 1'b1, tag, eresp, edata, ewaits);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 32'd0, 1'b0, 3'b010, 32'd0, 2'b00, 1'b0, "idle", 2'b00, 32'd0, 0);
  endtask

  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ER  = 2'b01;

  // Bounded run time so a stuck bus still ends the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  // Main test sequence.
  initial begin
    HRESETn = 1'b0; hsel = 3'b000; haddr = 32'd0; hwdata = 32'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000; ext_hold = 1'b0; cur_tgt = 2'd0;
    pend_wdata = 32'd0;
`ifdef AHB_SLV_RETRY_EN
    busy = 1'b0;
`endif
    repeat (3) @(negedge HCLK);
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("rst_ready_s%0d", s), 32'(hreadyout_v[s]), 32'd1);
      checkOutput($sformatf("rst_resp_s%0d", s), 32'(hresp_v[s]), 32'd0);
      checkOutput($sformatf("rst_rdata_s%0d", s), hrdata_v[s], 32'd0);
    end
    HRESETn = 1'b1;

    $display("[TB] single write/read with one wait state");
    writeBeat(0, 32'h000, 3'b010, 32'h1111_1111, NSQ, "s0_w0", OK, 1);
    readBeat (0, 32'h000, 3'b010, NSQ, "s0_r0", OK, 32'h1111_1111, 1);
    writeBeat(0, 32'h020, 3'b010, 32'hCAFE_0020, NSQ, "s0_w20", OK, 1);
    idleCycles(3);

    $display("[TB] INCR4 burst with zero wait states");
    hburst = 3'b011;
    writeBeat(1, 32'h100, 3'b010, 32'h1111_1111, NSQ, "b_w0", OK, 0);
    writeBeat(1, 32'h104, 3'b010, 32'h2222_2222, SQ,  "b_w4", OK, 0);
    writeBeat(1, 32'h108, 3'b010, 32'h3333_3333, SQ,  "b_w8", OK, 0);
    writeBeat(1, 32'h10C, 3'b010, 32'h4444_4444, SQ,  "b_wC", OK, 0);
    readBeat (1, 32'h100, 3'b010, NSQ, "b_r0", OK, 32'h1111_1111, 0);
    readBeat (1, 32'h104, 3'b010, SQ,  "b_r4", OK, 32'h2222_2222, 0);
    readBeat (1, 32'h108, 3'b010, SQ,  "b_r8", OK, 32'h3333_3333, 0);
    readBeat (1, 32'h10C, 3'b010, SQ,  "b_rC", OK, 32'h4444_4444, 0);
    hburst = 3'b000;

    $display("[TB] byte and halfword lanes");
    writeBeat(1, 32'h104, 3'b010, 32'h1234_5678, NSQ, "l_w4", OK, 0);
    writeBeat(1, 32'h105, 3'b000, 32'hABAB_ABAB, NSQ, "l_wb5", OK, 0);
    readBeat (1, 32'h104, 3'b010, NSQ, "l_r4", OK, 32'h1234_AB78, 0);
    writeBeat(1, 32'h10A, 3'b001, 32'hBEEF_BEEF, NSQ, "l_wh10A", OK, 0);
    readBeat (1, 32'h108, 3'b010, NSQ, "l_r8", OK, 32'hBEEF_3333, 0);
    idleCycles(2);

    $display("[TB] error responses");
    writeBeat(0, 32'h002, 3'b010, 32'hFFFF_FFFF, NSQ, "e_misw", ER, 1);
    writeBeat(0, 32'h001, 3'b001, 32'hFFFF_FFFF, NSQ, "e_mish", ER, 1);
    readBeat (0, 32'h000, 3'b011, NSQ, "e_size", ER, 32'd0, 1);
    writeBeat(0, 32'h100, 3'b010, 32'h0BAD_0BAD, NSQ, "e_top", ER, 1);
    readBeat (0, 32'h000, 3'b010, NSQ, "e_r0", OK, 32'h1111_1111, 1);
    readBeat (1, 32'h0FC, 3'b010, NSQ, "e_below", ER, 32'd0, 1);
    readBeat (1, 32'h100, 3'b010, NSQ, "e_r100", OK, 32'h1111_1111, 0);
    idleCycles(2);

    $display("[TB] BUSY transfer is a zero-wait OKAY");
    applyStimulus(0, 32'h000, 1'b1, 3'b010, 32'hFFFF_FFFF, 2'b01, 1'b0, "busy", OK, 32'd0, 0);
    @(negedge HCLK);
    htrans = 2'b00; hsel = 3'b000;
    #1;
    checkOutput("busy_ready", 32'(hreadyout_v[0]), 32'd1);
    checkOutput("busy_resp", 32'(hresp_v[0]), 32'd0);
    pend_wdata = 32'd0;
    idleCycles(2);

    $display("[TB] HREADY held low by another slave");
    @(negedge HCLK);
    ext_hold = 1'b1; hsel = 3'b001; cur_tgt = 2'd0; haddr = 32'h020; htrans = NSQ;
    hwrite = 1'b1; hsize = 3'b010; hwdata = 32'hFFFF_FFFF;
    @(negedge HCLK);
    #1;
    checkOutput("hold_no_capture", 32'(hreadyout_v[0]), 32'd1);
    htrans = 2'b00; hsel = 3'b000; ext_hold = 1'b0;
    readBeat(0, 32'h020, 3'b010, NSQ, "hold_r20", OK, 32'hCAFE_0020, 1);
    idleCycles(2);

    $display("[TB] reset during wait states");
    writeBeat(2, 32'h210, 3'b010, 32'h5555_AAAA, NSQ, "r_w", OK, 3);
    readBeat (2, 32'h210, 3'b010, NSQ, "r_r", OK, 32'h5555_AAAA, 3);
    idleCycles(2);
    applyStimulus(2, 32'h210, 1'b1, 3'b010, 32'hDEAD_BEEF, NSQ, 1'b0, "r_dead", OK, 32'd0, 0);
    @(negedge HCLK);
    hwdata = 32'hDEAD_BEEF; htrans = 2'b00; hsel = 3'b000;
    #1;
    checkOutput("rst_wait_ready", 32'(hreadyout_v[2]), 32'd0);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 32'(hreadyout_v[2]), 32'd1);
    checkOutput("rst_mid_resp", 32'(hresp_v[2]), 32'd0);
    pend_wdata = 32'd0;
    idleCycles(4);
    readBeat(2, 32'h210, 3'b010, NSQ, "r_old", OK, 32'h5555_AAAA, 3);
    idleCycles(2);

`ifdef AHB_SLV_RETRY_EN
    $display("[TB] retry response");
    writeBeat(0, 32'h030, 3'b010, 32'h3030_3030, NSQ, "y_w0", OK, 1);
    idleCycles(2);
    busy = 1'b1;
    writeBeat(0, 32'h030, 3'b010, 32'h9999_9999, NSQ, "y_rty", 2'b10, 1);
    idleCycles(4);
    busy = 1'b0;
    readBeat (0, 32'h030, 3'b010, NSQ, "y_r_old", OK, 32'h3030_3030, 1);
    writeBeat(0, 32'h030, 3'b010, 32'h9999_9999, NSQ, "y_w1", OK, 1);
    readBeat (0, 32'h030, 3'b010, NSQ, "y_r_new", OK, 32'h9999_9999, 1);
    idleCycles(2);
`endif

    idleCycles(4);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite-style slave port with a local register-array memory, sitting directly downstream of the AHB master port (ahb_master_top) on the shared AHB bus.
- Consumes the master's address and data phases and returns HREADYOUT, HRESP and HRDATA.
- Inserts programmable wait states and generates the two-cycle ERROR response.
- Provides the target the master's wait, error and retry handling is exercised against.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*4.
- WAIT_STATES, 1, HREADYOUT-low cycles per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal.
- HBURST  in  3  burst type; accepted, not used internally.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus-level ready; address phase sampled only when 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR, 10 RETRY.
- HRDATA  out  32  read data.

Behaviour:
- Reset: one HCLK edge with HRESETn=0 sets state=IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter=0 and all captured address-phase registers=0. Memory contents are not cleared.
- Address-phase capture: happens on an edge with HSEL=1, HREADY=1 and HTRANS[1]=1. Captured fields are HADDR, HWRITE and HSIZE.
- Capture with HTRANS IDLE/BUSY or HSEL=0: next cycle is a zero-wait OKAY and memory is untouched.
- Legality check at capture: the transfer is an error if any of the following holds:
  - HSIZE > 010;
  - the address is misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=0);
  - HADDR < BASE_ADDR or HADDR >= BASE_ADDR+4*MEM_DEPTH.
- States:
  - IDLE: HREADYOUT=1, HRESP=00.
  - Legal capture with WAIT_STATES>0 goes to WAIT; with WAIT_STATES=0 goes to DONE.
  - Illegal capture goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. Counter counts from 1 to WAIT_STATES, then goes to DONE.
  - DONE: HREADYOUT=1, HRESP=00.
    - Write: the byte lanes selected by HSIZE and HADDR[1:0] (little-endian) are updated from HWDATA at the end of this cycle.
    - Read: HRDATA = mem[word index] combinationally in this cycle; HRDATA is 0 outside DONE.
    - Next state comes from a new capture on the same edge, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=01. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Goes to the next state from a capture, else IDLE.
  - Errored writes never modify memory.
- Pipelining: back-to-back NONSEQ/SEQ transfers are accepted at DONE/ERR2, so latency is exactly WAIT_STATES+1 cycles per OKAY beat.
- Read-after-write to the same address, back-to-back, returns the new data. The write commits at the end of DONE; the following read's DONE is no earlier than the next cycle.
- HREADY=0 from another slave while IDLE: no capture occurs.
- Reset mid-WAIT/ERR1: the transfer is abandoned, no write occurs, and the outputs take their reset values on the next edge.
- HSEL deasserted during WAIT: ignored; the data phase completes normally.

Optional Feature:
- Macro: AHB_SLV_RETRY_EN.
- Defined: adds input port slave_busy (1 bit) and states RTY1 and RTY2.
  - A legal capture with slave_busy=1 on the capture edge goes to RTY1.
  - RTY1: HREADYOUT=0, HRESP=10.
  - RTY2: HREADYOUT=1, HRESP=10.
  - No memory write occurs; exit from RTY2 follows the ERR2 rules.
- Undefined: the slave_busy port does not exist and HRESP never equals 10.

Test Plan:
- Write word 32'h1111_1111 to BASE_ADDR+0, WAIT_STATES=1, then read the same address -> each beat shows HREADYOUT 0 then 1; the read returns 32'h1111_1111 with HRESP=00.
- INCR4 writes 1111_1111/2222_2222/3333_3333/4444_4444 to +0/+4/+8/+C, NONSEQ then 3 SEQ, WAIT_STATES=0 -> HREADYOUT stays 1 throughout; a readback returns all four values in order.
- Byte write 8'hAB at address +5 over word 32'h1234_5678 at +4 -> a read of +4 returns 32'h1234_AB78.
- Word access at +2 (misaligned), and word access at BASE_ADDR+4*MEM_DEPTH -> each gives ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01); memory unchanged.
- HRESETn=0 for one edge during WAIT of a write of 32'hDEAD_BEEF (WAIT_STATES=3) -> next cycle HREADYOUT=1, HRESP=00; a later read shows the old value.
- AHB_SLV_RETRY_EN defined, slave_busy=1 at a write capture -> RTY1 (HREADYOUT=0, HRESP=10), RTY2 (HREADYOUT=1, HRESP=10), no write; a repeat with slave_busy=0 completes OKAY.
